// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring-divide core
// with a sign/special-case fix-up cycle, fixed 34-cycle accept-to-done latency.
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [4:0] {
        OP_MUL    = 5'b01011,
        OP_MULH   = 5'b01100,
        OP_MULHSU = 5'b01101,
        OP_MULHU  = 5'b01110,
        OP_DIV    = 5'b01111,
        OP_DIVU   = 5'b10000,
        OP_REM    = 5'b10001,
        OP_REMU   = 5'b10010
    } op_t;

    state_t              state;
    op_t                 op_q;
    logic [CW-1:0]       cnt;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN:0]       prem;
    logic [XLEN-1:0]     divisor;
    logic                neg_main;
    logic                neg_rem;

    logic                op_valid;
    logic                accept;
    logic                sgn_a_in;
    logic                sgn_b_in;
    logic [XLEN-1:0]     mag_a_in;
    logic [XLEN-1:0]     mag_b_in;
    logic                is_div;
    logic [XLEN:0]       rem_sh;
    logic [XLEN+1:0]     diff;
    logic                q_bit;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     fix_result;
    logic                div_zero;
    logic                div_ovf;

    always_comb begin
        op_valid = alu_op inside {[5'b01011:5'b10010]};
        accept   = start && op_valid && (state == IDLE || state == DONE);
        busy     = (state == CALC) || (state == FIX) || (accept && !flush);

        sgn_a_in = (alu_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[XLEN-1];
        sgn_b_in = (alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[XLEN-1];
        mag_a_in = sgn_a_in ? -SrcA : SrcA;
        mag_b_in = sgn_b_in ? -SrcB : SrcB;
    end

    // Restoring-division step: shift in the next dividend bit, keep the
    // difference only when the trial subtraction does not borrow.
    always_comb begin
        is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        rem_sh = {prem[XLEN-1:0], quot[XLEN-1]};
        diff   = {1'b0, rem_sh} - {2'b00, divisor};
        q_bit  = ~diff[XLEN+1];
    end

    always_comb begin
        prod_fix = neg_main ? -prod : prod;
        quot_fix = neg_main ? -quot : quot;
        rem_fix  = neg_rem ? -prem[XLEN-1:0] : prem[XLEN-1:0];
        div_zero = (b_q == '0);
        div_ovf  = (op_q == OP_DIV || op_q == OP_REM)
                   && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

        unique case (op_q)
            OP_MUL:                      fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_result = quot_fix;
            default:                     fix_result = rem_fix;
        endcase

        if (div_zero && (op_q == OP_DIV || op_q == OP_DIVU))
            fix_result = '1;
        else if (div_zero && (op_q == OP_REM || op_q == OP_REMU))
            fix_result = a_q;
        else if (div_ovf)
            fix_result = (op_q == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            quot     <= '0;
            prem     <= '0;
            divisor  <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            op_q     <= op_t'(alu_op);
                            a_q      <= SrcA;
                            b_q      <= SrcB;
                            mcand    <= {{XLEN{1'b0}}, mag_a_in};
                            mplier   <= mag_b_in;
                            prod     <= '0;
                            quot     <= mag_a_in;
                            prem     <= '0;
                            divisor  <= mag_b_in;
                            neg_main <= sgn_a_in ^ sgn_b_in;
                            neg_rem  <= sgn_a_in;
                            cnt      <= '0;
                            state    <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        if (is_div) begin
                            prem <= q_bit ? diff[XLEN:0] : rem_sh;
                            quot <= {quot[XLEN-2:0], q_bit};
                        end else begin
                            if (mplier[0])
                                prod <= prod + mcand;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= FIX;
                    end
                    FIX: begin
                        result <= fix_result;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: expected results are queued at issue and
// checked when done pulses, along with latency, busy and abort behaviour.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [4:0]  alu_op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result = '0;

    localparam logic [4:0] MUL    = 5'b01011;
    localparam logic [4:0] MULH   = 5'b01100;
    localparam logic [4:0] MULHSU = 5'b01101;
    localparam logic [4:0] MULHU  = 5'b01110;
    localparam logic [4:0] DIV    = 5'b01111;
    localparam logic [4:0] DIVU   = 5'b10000;
    localparam logic [4:0] REM    = 5'b10001;
    localparam logic [4:0] REMU   = 5'b10010;

    mdu_iterative #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .alu_op (alu_op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one start strobe; 'now' issues in the current (already sampled) cycle.
    task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit push,
                         input bit now);
        if (!now) @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        SrcA   = a;
        SrcB   = b;
        #1 check({tag, "_busy_issue"}, {31'd0, busy}, 32'd1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for done, checking latency, busy and the scoreboard result.
    task automatic collect(input string tag, input int inject_at);
        int lat = 0;
        int not_busy = 0;
        logic [31:0] e;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (inject_at != 0 && k == inject_at + 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) not_busy++;
            if (k == inject_at) begin
                start  = 1'b1;
                alu_op = DIVU;
                SrcA   = 32'd5;
                SrcB   = 32'd1;
            end
        end
        check({tag, "_latency"}, lat, 34);
        check({tag, "_busy_calc"}, not_busy, 0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, result, e);
            last_result = e;
        end else begin
            check({tag, "_scoreboard"}, exp_q.size(), 1);
        end
    endtask

    task automatic finish_idle(input string tag);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(tag, op, a, b, exp, 1'b1, 1'b0);
        collect(tag, 0);
        finish_idle(tag);
    endtask

    initial begin
        int done_cnt;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        alu_op = '0;
        SrcA   = '0;
        SrcB   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        // Invalid opcode just above the M range must be ignored
        @(negedge clk);
        start  = 1'b1;
        alu_op = 5'b10011;
        SrcA   = 32'd9;
        SrcB   = 32'd3;
        #1 check("badop_busy_issue", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("badop_busy_after", {31'd0, busy}, 32'd0);
        check("badop_done_after", {31'd0, done}, 32'd0);

        run("mul",        MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run("mulhu",      MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006);
        run("mulh_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        run("mulhsu",     MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("div_neg",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
        run("rem_neg",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
        run("divu",       DIVU,   32'd100,      32'd7,        32'd14);
        run("remu",       REMU,   32'd100,      32'd7,        32'd2);
        run("div_zero",   DIV,    32'h12345678, 32'd0,        32'hFFFFFFFF);
        run("rem_zero",   REM,    32'h12345678, 32'd0,        32'h12345678);
        run("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        // A start during CALC must not disturb the running operation
        issue("ign", MUL, 32'h00012345, 32'h00000100, 32'h01234500, 1'b1, 1'b0);
        collect("ign", 10);
        finish_idle("ign");

        // Back-to-back: second op issued in the DONE cycle of the first
        issue("b2b1", REMU, 32'd100, 32'd7, 32'd2, 1'b1, 1'b0);
        collect("b2b1", 0);
        issue("b2b2", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1);
        collect("b2b2", 0);
        finish_idle("b2b2");

        // Flush mid-CALC: back to IDLE, no done, result untouched
        issue("flush", DIVU, 32'h0000FFFF, 32'd3, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, last_result);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) done_cnt++;
        end
        check("flush_no_done", done_cnt, 0);
        run("div_after_flush", DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);

        // Asynchronous reset mid-CALC clears outputs immediately
        issue("rstmid", MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("rem_after_reset", REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
